cache_arbiter: RTL and testbench

- Sits between the datapath's icache and dcache request ports and a single word-wide physical memory port.
- Responds to both request ports and forwards one transaction at a time downstream, returning the read data to the requester that issued it.
- Contention between the two ports is resolved by alternating priority.
- All downstream outputs and both response strobes are registered.

---
 rtl/arbiter_types.sv | 6 +
 rtl/cache_arbiter.sv | 125 ++++++++++++
 tb/tb_cache_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_types.sv
// arbiter_types: state, grant and byte-lane definitions shared by cache_arbiter
package arbiter_types;
    typedef enum logic [2:0] {IDLE, I_REQ, D_REQ, I_RESP, D_RESP} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;
    localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: alternating-priority arbiter merging icache and dcache requests onto one memory port
module cache_arbiter
    import arbiter_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_read,
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_rdata,
    output logic        icache_resp,
    input  logic        dcache_read,
    input  logic        dcache_write,
    input  logic [3:0]  dcache_byte_enable,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    output logic [31:0] dcache_rdata,
    output logic        dcache_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);
    arb_state_t  state_q, state_d;
    grant_t      last_grant_q, last_grant_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic        i_resp_q, i_resp_d, d_resp_q, d_resp_d;
    logic        i_pend, d_pend;

    assign i_pend = icache_read;
    assign d_pend = dcache_read | dcache_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // dcache wins contention only when icache was served last
                if (d_pend && (!i_pend || last_grant_q == GRANT_I)) begin
                    state_d      = D_REQ;
                    last_grant_d = GRANT_D;
                    mem_read_d   = ~dcache_write;
                    mem_write_d  = dcache_write;
                    mem_addr_d   = {dcache_addr[31:2], 2'b00};
                    mem_be_d     = dcache_write ? dcache_byte_enable : BE_ALL;
                    mem_wdata_d  = dcache_wdata;
                end else if (i_pend) begin
                    state_d      = I_REQ;
                    last_grant_d = GRANT_I;
                    mem_read_d   = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {icache_addr[31:2], 2'b00};
                    mem_be_d     = BE_ALL;
                    mem_wdata_d  = '0;
                end
            end
            I_REQ: if (mem_resp) begin
                state_d    = I_RESP;
                mem_read_d = 1'b0;
                i_resp_d   = 1'b1;
                i_rdata_d  = mem_rdata;
            end
            D_REQ: if (mem_resp) begin
                state_d     = D_RESP;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                d_resp_d    = 1'b1;
                d_rdata_d   = mem_write_q ? '0 : mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_addr        = mem_addr_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_wdata       = mem_wdata_q;
    assign icache_rdata    = i_rdata_q;
    assign icache_resp     = i_resp_q;
    assign dcache_rdata    = d_rdata_q;
    assign dcache_resp     = d_resp_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized requesters and memory checked against a transaction-level arbitration model
module tb_cache_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        icache_read;
    logic [31:0] icache_addr, icache_rdata;
    logic        icache_resp;
    logic        dcache_read, dcache_write;
    logic [3:0]  dcache_byte_enable;
    logic [31:0] dcache_addr, dcache_wdata, dcache_rdata;
    logic        dcache_resp;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_resp;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    bit i_pend, d_pend, d_rd, d_wr, last_d;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_addr(icache_addr),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_byte_enable(dcache_byte_enable), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply();
        icache_read        = i_pend;
        icache_addr        = i_addr;
        dcache_read        = d_pend && d_rd;
        dcache_write       = d_pend && d_wr;
        dcache_addr        = d_addr;
        dcache_wdata       = d_wdata;
        dcache_byte_enable = d_be;
    endtask

    task automatic new_i();
        i_pend = 1'b1;
        i_addr = $urandom;
    endtask

    task automatic new_d();
        logic [1:0] rw;
        rw      = 2'($urandom_range(1, 3));
        d_pend  = 1'b1;
        d_rd    = rw[0];
        d_wr    = rw[1];
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_read"}, 32'(mem_read), 32'(0));
        check({tag, "_mem_write"}, 32'(mem_write), 32'(0));
        check({tag, "_iresp"}, 32'(icache_resp), 32'(0));
        check({tag, "_dresp"}, 32'(dcache_resp), 32'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_quiet(tag);
        check({tag, "_mem_addr"}, mem_addr, 32'(0));
        check({tag, "_mem_be"}, 32'(mem_byte_enable), 32'(0));
        check({tag, "_mem_wdata"}, mem_wdata, 32'(0));
        check({tag, "_irdata"}, icache_rdata, 32'(0));
        check({tag, "_drdata"}, dcache_rdata, 32'(0));
    endtask

    // Requests must already be applied and the arbiter idle; grant shows one cycle later
    task automatic run_txn(input int hold, input logic [31:0] rd);
        bit wd, wr;
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        @(negedge clk);
        wd = d_pend && (!i_pend || !last_d);
        wr = wd && d_wr;
        ea = (wd ? d_addr : i_addr) & ~32'h3;
        eb = wr ? d_be : 4'hF;
        ew = d_wdata;
        for (int c = 0; c <= hold; c++) begin
            check("req_mem_read", 32'(mem_read), 32'(!wr));
            check("req_mem_write", 32'(mem_write), 32'(wr));
            check("req_mem_addr", mem_addr, ea);
            check("req_mem_be", 32'(mem_byte_enable), 32'(eb));
            if (wr) check("req_mem_wdata", mem_wdata, ew);
            check("req_iresp", 32'(icache_resp), 32'(0));
            check("req_dresp", 32'(dcache_resp), 32'(0));
            if (c < hold) begin
                if (wd) i_addr = $urandom;
                else begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    d_be    = 4'($urandom);
                end
                apply();
                @(negedge clk);
            end
        end
        mem_resp  = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
        check("resp_iresp", 32'(icache_resp), 32'(!wd));
        check("resp_dresp", 32'(dcache_resp), 32'(wd));
        if (wd) check("resp_drdata", dcache_rdata, wr ? 32'(0) : rd);
        else check("resp_irdata", icache_rdata, rd);
        check("resp_mem_read", 32'(mem_read), 32'(0));
        check("resp_mem_write", 32'(mem_write), 32'(0));
        last_d = wd;
        if (mode != 1) begin
            if (wd) d_pend = 1'b0;
            else i_pend = 1'b0;
        end
        if (mode == 2) begin
            if (!i_pend && $urandom_range(0, 1) == 1) new_i();
            if (!d_pend && $urandom_range(0, 1) == 1) new_d();
            if (!i_pend && !d_pend) begin
                if ($urandom_range(0, 1) == 1) new_i();
                else new_d();
            end
        end
        apply();
        @(negedge clk);
        check_quiet("after");
    endtask

    initial begin
        rst = 1'b1;
        i_pend = 0; d_pend = 0; d_rd = 0; d_wr = 0; last_d = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_resp = 1'b0;
        mem_rdata = 32'h0;
        apply();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // mem_resp while idle must be ignored
        @(negedge clk);
        mem_resp = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_resp = 1'b0;
        check_all_zero("idle_resp1");
        @(negedge clk);
        check_all_zero("idle_resp2");

        // continuous contention from reset: D, I, D, I
        mode = 1;
        i_pend = 1; i_addr = 32'h1000;
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h2000; d_wdata = 0; d_be = 4'h3;
        apply();
        for (int n = 0; n < 4; n++) run_txn(0, $urandom);
        mode = 0;
        i_pend = 0; d_pend = 0;
        apply();
        @(negedge clk);
        check_quiet("drain");

        i_pend = 1; i_addr = 32'h60;
        apply();
        run_txn(2, 32'h00A00093);

        d_pend = 1; d_rd = 0; d_wr = 1; d_addr = 32'h103; d_be = 4'b0100; d_wdata = 32'hDEADBEEF;
        apply();
        run_txn(1, $urandom);

        d_pend = 1; d_rd = 1; d_wr = 1; d_addr = 32'h206; d_be = 4'b1001; d_wdata = 32'hCAFEF00D;
        apply();
        run_txn(0, $urandom);

        mode = 2;
        new_i();
        if ($urandom_range(0, 1) == 1) new_d();
        apply();
        for (int n = 0; n < 150; n++) run_txn($urandom_range(0, 3), $urandom);
        mode = 0;
        i_pend = 0; d_pend = 0;
        apply();
        @(negedge clk);
        check_quiet("rand_drain");

        // asynchronous reset in the middle of an icache transaction
        i_pend = 1; i_addr = 32'hABCD0124;
        apply();
        @(negedge clk);
        check("ar_grant", 32'(mem_read), 32'(1));
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        i_pend = 0;
        apply();
        mem_resp = 1'b1;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_resp = 1'b0;
        check_all_zero("late_resp");
        last_d = 0;
        i_pend = 1; i_addr = 32'h300;
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h400;
        apply();
        run_txn(0, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
